sensor_conditioner: RTL and testbench



---
 rtl/home_automation_pkg.sv | 23 ++
 rtl/debounce_channel.sv | 68 ++++++
 rtl/sensor_conditioner.sv | 89 ++++++++
 tb/tb_sensor_conditioner.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/home_automation_pkg.sv
// ============================================================================
// Module  : home_automation_pkg
// Brief   : Shared sensor indices, widths and defaults for home automation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package home_automation_pkg;

  localparam int NUM_SENSORS             = 5;
  localparam int TEMP_W                  = 6;

  localparam int IDX_SFD                 = 0;
  localparam int IDX_SRD                 = 1;
  localparam int IDX_SFA                 = 2;
  localparam int IDX_SW                  = 3;
  localparam int IDX_ST                  = 4;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

endpackage : home_automation_pkg

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// Module  : debounce_channel
// Brief   : Two-flop synchroniser plus whole-word debouncer with accept strobe.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_channel #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_value,
  output logic             o_updated
);

  localparam logic [CNT_W-1:0] C_TARGET = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_out;
  logic [CNT_W-1:0] r_cnt;

  logic             w_mismatch;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_accept;

  // A different value than the current candidate restarts the count at 1,
  // which is what lets DEBOUNCE_CYCLES = 1 accept on the first mismatch edge.
  always_comb begin
    w_mismatch = (r_s2 != r_out);
    w_cnt_next = (r_s2 == r_cand) ? (r_cnt + C_ONE) : C_ONE;
    w_accept   = w_mismatch && (w_cnt_next == C_TARGET);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_cand <= '0;
      r_out  <= '0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      r_cand <= r_s2;
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_out <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_next;
      end
    end
  end

  assign o_value   = r_out;
  assign o_updated = w_accept && !reset;

endmodule : debounce_channel

`default_nettype wire

// File: rtl/sensor_conditioner.sv
// ============================================================================
// Module  : sensor_conditioner
// Brief   : Synchronises and debounces the five sensor bits and temperature.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sensor_conditioner
  import home_automation_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SFD_raw,
  input  logic              SRD_raw,
  input  logic              SFA_raw,
  input  logic              SW_raw,
  input  logic              ST_raw,
  input  logic [TEMP_W-1:0] temperature_raw,
  output logic              SFD,
  output logic              SRD,
  output logic              SFA,
  output logic              SW,
  output logic              ST,
  output logic [TEMP_W-1:0] temperature,
  output logic              sensor_change
);

  logic [NUM_SENSORS-1:0] w_raw;
  logic [NUM_SENSORS-1:0] w_out;
  logic [NUM_SENSORS:0]   w_upd;
  logic                   r_change;

  always_comb begin
    w_raw          = '0;
    w_raw[IDX_SFD] = SFD_raw;
    w_raw[IDX_SRD] = SRD_raw;
    w_raw[IDX_SFA] = SFA_raw;
    w_raw[IDX_SW]  = SW_raw;
    w_raw[IDX_ST]  = ST_raw;
  end

  for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_bit
    debounce_channel #(
      .WIDTH           (1),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk       (clk),
      .reset     (reset),
      .i_raw     (w_raw[gi]),
      .o_value   (w_out[gi]),
      .o_updated (w_upd[gi])
    );
  end

  // Temperature is debounced as one word so a half-updated value never escapes.
  debounce_channel #(
    .WIDTH           (TEMP_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_temp (
    .clk       (clk),
    .reset     (reset),
    .i_raw     (temperature_raw),
    .o_value   (temperature),
    .o_updated (w_upd[NUM_SENSORS])
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_change <= 1'b0;
    end else begin
      r_change <= |w_upd;
    end
  end

  assign SFD           = w_out[IDX_SFD];
  assign SRD           = w_out[IDX_SRD];
  assign SFA           = w_out[IDX_SFA];
  assign SW            = w_out[IDX_SW];
  assign ST            = w_out[IDX_ST];
  assign sensor_change = r_change;

endmodule : sensor_conditioner

`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
// ============================================================================
// Module  : tb_sensor_conditioner
// Brief   : Directed self-checking bench for sensor_conditioner (default params).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sensor_conditioner;

  logic       clk;
  logic       reset;
  logic       SFD_raw, SRD_raw, SFA_raw, SW_raw, ST_raw;
  logic [5:0] temperature_raw;
  logic       SFD, SRD, SFA, SW, ST;
  logic [5:0] temperature;
  logic       sensor_change;

  int n_cmp;
  int n_bad;

  // Observation vector: {SFD,SRD,SFA,SW,ST,temperature,sensor_change}
  logic [11:0] obs;
  assign obs = {SFD, SRD, SFA, SW, ST, temperature, sensor_change};

  sensor_conditioner dut (
    .clk             (clk),
    .reset           (reset),
    .SFD_raw         (SFD_raw),
    .SRD_raw         (SRD_raw),
    .SFA_raw         (SFA_raw),
    .SW_raw          (SW_raw),
    .ST_raw          (ST_raw),
    .temperature_raw (temperature_raw),
    .SFD             (SFD),
    .SRD             (SRD),
    .SFA             (SFA),
    .SW              (SW),
    .ST              (ST),
    .temperature     (temperature),
    .sensor_change   (sensor_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then sample at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset with the given raw pattern and let everything settle.
  task automatic baseline(input logic [4:0] bits, input logic [5:0] temp);
    reset = 1'b1;
    {SFD_raw, SRD_raw, SFA_raw, SW_raw, ST_raw} = bits;
    temperature_raw = temp;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_reset();
    logic [11:0] exp;
    int pulses;
    @(negedge clk);
    reset = 1'b1;
    {SFD_raw, SRD_raw, SFA_raw, SW_raw, ST_raw} = 5'b11111;
    temperature_raw = 6'd40;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (obs !== 12'h000) begin
        n_bad++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, obs, 12'h000);
      end
    end
    reset = 1'b0;
    pulses = 0;
    for (int e = 0; e < 9; e++) begin
      step();
      if (sensor_change === 1'b1) pulses++;
      exp = (e >= 5) ? {5'b11111, 6'd40, (e == 5)} : 12'h000;
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL reset_release e=%0d got=%h exp=%h", e, obs, exp);
      end
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++;
      $display("FAIL reset_release_pulses got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_sfd_rise();
    logic [11:0] exp;
    baseline(5'b00000, 6'd0);
    SFD_raw = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step();
      exp = {(e >= 5), 4'b0000, 6'd0, (e == 5)};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL sfd_rise e=%0d got=%h exp=%h", e, obs, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [11:0] exp;
    baseline(5'b00000, 6'd0);
    for (int e = 0; e < 12; e++) begin
      SW_raw = (e < 3);
      step();
      n_cmp++;
      if (obs !== 12'h000) begin
        n_bad++;
        $display("FAIL glitch3 e=%0d got=%h exp=%h", e, obs, 12'h000);
      end
    end
    for (int e = 0; e < 14; e++) begin
      SW_raw = (e < 4);
      step();
      exp = {3'b000, (e >= 5 && e <= 8), 1'b0, 6'd0, (e == 5 || e == 9)};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL glitch4 e=%0d got=%h exp=%h", e, obs, exp);
      end
    end
  endtask

  task automatic test_temperature();
    logic [11:0] exp;
    baseline(5'b00000, 6'd20);
    n_cmp++;
    if (obs !== {5'b00000, 6'd20, 1'b0}) begin
      n_bad++;
      $display("FAIL temp_base got=%h exp=%h", obs, {5'b00000, 6'd20, 1'b0});
    end
    for (int e = 0; e < 11; e++) begin
      temperature_raw = (e < 2) ? 6'd33 : 6'd35;
      step();
      exp = {5'b00000, (e >= 7) ? 6'd35 : 6'd20, (e == 7)};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL temp_word e=%0d got=%h exp=%h", e, obs, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [11:0] exp;
    baseline(5'b00000, 6'd0);
    SFA_raw = 1'b1;
    ST_raw  = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step();
      exp = {2'b00, (e >= 5), 1'b0, (e >= 5), 6'd0, (e == 5)};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL simultaneous e=%0d got=%h exp=%h", e, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [11:0] exp;
    baseline(5'b00000, 6'd0);
    SRD_raw = 1'b1;
    for (int e = 0; e < 3; e++) step();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (obs !== 12'h000) begin
        n_bad++;
        $display("FAIL reset_mid_hold cyc=%0d got=%h exp=%h", i, obs, 12'h000);
      end
    end
    reset = 1'b0;
    for (int e = 0; e < 8; e++) begin
      step();
      exp = {1'b0, (e >= 5), 3'b000, 6'd0, (e == 5)};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL reset_mid_release e=%0d got=%h exp=%h", e, obs, exp);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    {SFD_raw, SRD_raw, SFA_raw, SW_raw, ST_raw} = 5'b00000;
    temperature_raw = 6'd0;
    test_reset();
    test_sfd_rise();
    test_glitch();
    test_temperature();
    test_simultaneous();
    test_reset_mid_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_sensor_conditioner

`default_nettype wire
